// File: rtl/mmio_pkg.sv
// Shared register-map constants and types for the memory-mapped timer bank.
package mmio_pkg;

  localparam logic [31:0] OFF_TH    = 32'h0000_0000;
  localparam logic [31:0] OFF_TL    = 32'h0000_0004;
  localparam logic [31:0] OFF_TCON  = 32'h0000_0008;
  localparam logic [31:0] OFF_PRESC = 32'h0000_000C;
  localparam logic [31:0] OFF_GSTAT = 32'h0000_0100;
  localparam int unsigned CH_STRIDE = 16;

  localparam int unsigned EN      = 0;
  localparam int unsigned IRQEN   = 1;
  localparam int unsigned STAT    = 2;
  localparam int unsigned ONESHOT = 3;

  typedef enum logic [1:0] {
    REG_TH    = 2'd0,
    REG_TL    = 2'd1,
    REG_TCON  = 2'd2,
    REG_PRESC = 2'd3
  } reg_sel_e;

  typedef struct packed {
    logic oneshot;
    logic status;
    logic irq_en;
    logic en;
  } tcon_t;

  // One-hot register select from the low nibble of a channel offset.
  function automatic logic [3:0] reg_onehot(input logic [3:0] off_lo);
    return {off_lo == OFF_PRESC[3:0], off_lo == OFF_TCON[3:0],
            off_lo == OFF_TL[3:0],    off_lo == OFF_TH[3:0]};
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: reload, counter, control, prescaler and tick/overflow logic.
module timer_channel
  import mmio_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       wsel_i,
  input  logic [CNT_W-1:0] wdata_i,
  output logic [CNT_W-1:0] th_o,
  output logic [CNT_W-1:0] tl_o,
  output logic [CNT_W-1:0] presc_o,
  output tcon_t            tcon_o
);

  logic [CNT_W-1:0] th_q, th_d;
  logic [CNT_W-1:0] tl_q, tl_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  tcon_t            tcon_q, tcon_d;
  logic             tick;
  logic             ovf;

  always_comb begin
    th_d    = th_q;
    tl_d    = tl_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    tcon_d  = tcon_q;
    tick    = tcon_q.en && (pcnt_q == presc_q);
    ovf     = tick && (tl_q == '1);

    if (wsel_i[REG_PRESC] || !tcon_q.en || tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + CNT_W'(1);
    end

    if (wsel_i[REG_TH])    th_d    = wdata_i;
    if (wsel_i[REG_PRESC]) presc_d = wdata_i;

    // CPU write beats the increment; overflow reloads from the pre-write TH.
    if (wsel_i[REG_TL]) begin
      tl_d = wdata_i;
    end else if (ovf) begin
      tl_d = th_q;
    end else if (tick) begin
      tl_d = tl_q + CNT_W'(1);
    end

    if (wsel_i[REG_TCON]) begin
      tcon_d.en      = wdata_i[EN];
      tcon_d.irq_en  = wdata_i[IRQEN];
      tcon_d.oneshot = wdata_i[ONESHOT];
      if (wdata_i[STAT]) tcon_d.status = 1'b0;
    end else if (ovf && tcon_q.oneshot) begin
      tcon_d.en = 1'b0;
    end

    // A hardware set always dominates a same-edge write-1-to-clear.
    if (ovf) tcon_d.status = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q    <= '0;
      tl_q    <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
      tcon_q  <= '0;
    end else begin
      th_q    <= th_d;
      tl_q    <= tl_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      tcon_q  <= tcon_d;
    end
  end

  assign th_o    = th_q;
  assign tl_o    = tl_q;
  assign presc_o = presc_q;
  assign tcon_o  = tcon_q;

endmodule

// File: rtl/mmio_timer_bank.sv
// Memory-mapped bank of NUM_CH independent timers with combinational read-back.
module mmio_timer_bank
  import mmio_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       MemBus_Address,
  input  logic [31:0]       MemBus_Write_Data,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [31:0]       Device_Read_Data,
  output logic [NUM_CH-1:0] irq
);

  logic [31:0]      addr_al;
  logic [31:0]      off;
  logic             in_win;
  logic             gstat_hit;
  logic             ch_hit;
  logic [3:0]       ch_idx;
  reg_sel_e         sel;
  logic [3:0]       reg_oh;

  logic [CNT_W-1:0] th_a    [NUM_CH];
  logic [CNT_W-1:0] tl_a    [NUM_CH];
  logic [CNT_W-1:0] presc_a [NUM_CH];
  tcon_t            tcon_a  [NUM_CH];
  logic [NUM_CH-1:0] status_v;
  logic [NUM_CH-1:0] irqen_v;

  logic unused_bits;
  assign unused_bits = ^{MemBus_Address[1:0], MemBus_Write_Data};

  // Word-aligned decode relative to the window base.
  assign addr_al   = {MemBus_Address[31:2], 2'b00};
  assign off       = addr_al - BASE_ADDR;
  assign in_win    = (addr_al >= BASE_ADDR) && (off <= OFF_GSTAT);
  assign gstat_hit = in_win && (off == OFF_GSTAT);
  assign ch_idx    = 4'(off / CH_STRIDE);
  assign ch_hit    = in_win && (off < OFF_GSTAT) && (32'(ch_idx) < NUM_CH);
  assign sel       = reg_sel_e'(off[3:2]);
  assign reg_oh    = reg_onehot(off[3:0]);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [3:0] wsel;
    assign wsel = (MemWrite && ch_hit && (ch_idx == 4'(g))) ? reg_oh : 4'b0000;

    timer_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .wsel_i  (wsel),
      .wdata_i (MemBus_Write_Data[CNT_W-1:0]),
      .th_o    (th_a[g]),
      .tl_o    (tl_a[g]),
      .presc_o (presc_a[g]),
      .tcon_o  (tcon_a[g])
    );
  end

  always_comb begin
    status_v = '0;
    irqen_v  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      status_v[i] = tcon_a[i].status;
      irqen_v[i]  = tcon_a[i].irq_en;
    end
  end

  assign irq = status_v & irqen_v;

  // Zero-latency read mux; registers are zero-extended to the bus width.
  always_comb begin
    Device_Read_Data = '0;
    if (MemRead && !reset) begin
      if (gstat_hit) begin
        Device_Read_Data = 32'(status_v);
      end else if (ch_hit) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_idx == 4'(i)) begin
            case (sel)
              REG_TH:    Device_Read_Data = 32'(th_a[i]);
              REG_TL:    Device_Read_Data = 32'(tl_a[i]);
              REG_TCON:  Device_Read_Data = {28'b0, tcon_a[i]};
              REG_PRESC: Device_Read_Data = 32'(presc_a[i]);
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Self-checking bench for mmio_timer_bank: register table plus timed counter sequences.
module tb_mmio_timer_bank;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] rdata;
  logic [3:0]  irq;

  always #10 clk = ~clk;

  mmio_timer_bank #(
    .NUM_CH    (4),
    .CNT_W     (32),
    .BASE_ADDR (32'h4000_0000)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .MemBus_Address    (addr),
    .MemBus_Write_Data (wdata),
    .MemRead           (rd_en),
    .MemWrite          (wr_en),
    .Device_Read_Data  (rdata),
    .irq               (irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       nm;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       nm;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[11];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    sb_t e;
    sb_t f;
    e.nm  = nm;
    e.exp = exp;
    addr  = a;
    rd_en = 1'b1;
    sb_q.push_back(e);
    #1;
    f = sb_q.pop_front();
    chk(f.nm, rdata, f.exp);
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic reset_table(input string tag);
    for (int ch = 0; ch < 4; ch++) begin
      for (int r = 0; r < 4; r++) begin
        cyc();
        rd($sformatf("%s ch%0d reg%0d", tag, ch, r), B + 32'(ch * 16 + r * 4), 32'h0);
      end
    end
    cyc();
    rd({tag, " gstat"}, B + 32'h100, 32'h0);
    chk({tag, " irq"}, 32'(irq), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{"ch3 TH",           B + 32'h30,  32'h1234_5678, B + 32'h30,  32'h1234_5678};
    vt[1]  = '{"ch3 TL",           B + 32'h34,  32'hCAFE_F00D, B + 32'h34,  32'hCAFE_F00D};
    vt[2]  = '{"ch3 PRESC",        B + 32'h3C,  32'h0000_0007, B + 32'h3C,  32'h0000_0007};
    vt[3]  = '{"ch3 TCON bits",    B + 32'h38,  32'hFFFF_FFF6, B + 32'h38,  32'h0000_0002};
    vt[4]  = '{"ch3 TCON oneshot", B + 32'h38,  32'hFFFF_FFFA, B + 32'h38,  32'h0000_000A};
    vt[5]  = '{"absent ch5",       B + 32'h50,  32'hDEAD_BEEF, B + 32'h50,  32'h0000_0000};
    vt[6]  = '{"gstat readonly",   B + 32'h100, 32'h0000_000F, B + 32'h100, 32'h0000_0000};
    vt[7]  = '{"misaligned TH",    B + 32'h33,  32'h0000_ABCD, B + 32'h30,  32'h0000_ABCD};
    vt[8]  = '{"outside window",   B + 32'h200, 32'h0000_0001, B + 32'h3D,  32'h0000_0007};
    vt[9]  = '{"beyond gstat",     B + 32'h104, 32'h0000_0055, B + 32'h104, 32'h0000_0000};
    vt[10] = '{"below base",       B - 32'h4,   32'h0000_0066, B + 32'h34,  32'hCAFE_F00D};

    reset = 1'b1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    reset_table("reset");

    for (int i = 0; i < 11; i++) begin
      wr(vt[i].waddr, vt[i].wdata);
      cyc();
      rd(vt[i].nm, vt[i].raddr, vt[i].exp);
    end
    cyc();
    rd("read below base", B - 32'h4, 32'h0);

    // ch0 periodic overflow with PRESC=0
    wr(B + 32'h0, 32'hFFFF_FFF0);
    wr(B + 32'h4, 32'hFFFF_FFFE);
    wr(B + 32'hC, 32'h0);
    wr(B + 32'h8, 32'h3);
    cyc(); rd("ch0 TL t0", B + 32'h4, 32'hFFFF_FFFE); chk("ch0 irq before", 32'(irq), 32'h0);
    cyc(); rd("ch0 TL t1", B + 32'h4, 32'hFFFF_FFFF);
    cyc(); rd("ch0 TL reload", B + 32'h4, 32'hFFFF_FFF0);
    rd("ch0 TCON status", B + 32'h8, 32'h7);
    rd("gstat ch0", B + 32'h100, 32'h1);
    chk("ch0 irq set", 32'(irq), 32'h1);
    cyc(); rd("ch0 TL continue", B + 32'h4, 32'hFFFF_FFF1);

    wr(B + 32'h8, 32'h7);
    cyc(); rd("ch0 w1c clear", B + 32'h8, 32'h3); chk("ch0 irq cleared", 32'(irq), 32'h0);

    // clear on the exact overflow edge
    wr(B + 32'h4, 32'hFFFF_FFFF);
    wr(B + 32'h8, 32'h7);
    cyc(); rd("ch0 set wins", B + 32'h8, 32'h7);
    rd("ch0 TL at set", B + 32'h4, 32'hFFFF_FFF0);
    chk("ch0 irq set wins", 32'(irq), 32'h1);

    // TH write on the overflow edge reloads the old TH
    wr(B + 32'h4, 32'hFFFF_FFFF);
    wr(B + 32'h0, 32'h77);
    cyc(); rd("ch0 old TH reload", B + 32'h4, 32'hFFFF_FFF0);
    rd("ch0 new TH", B + 32'h0, 32'h77);

    wr(B + 32'h8, 32'h7);
    cyc(); rd("ch0 later clear", B + 32'h8, 32'h3); chk("ch0 irq later", 32'(irq), 32'h0);

    // TL write on a tick edge
    wr(B + 32'h4, 32'h100);
    cyc(); rd("ch0 TL write wins", B + 32'h4, 32'h100);
    cyc(); rd("ch0 TL after write", B + 32'h4, 32'h101);
    wr(B + 32'h8, 32'h4);
    cyc(); rd("ch0 disabled TCON", B + 32'h8, 32'h0);
    rd("ch0 TL last tick", B + 32'h4, 32'h103);
    cyc(); rd("ch0 TL held", B + 32'h4, 32'h103);

    // ch1 one-shot with PRESC=3
    wr(B + 32'h1C, 32'h3);
    wr(B + 32'h14, 32'hFFFF_FFFF);
    wr(B + 32'h10, 32'h5);
    wr(B + 32'h18, 32'h9);
    for (int k = 0; k < 4; k++) begin
      cyc();
      rd($sformatf("ch1 TL wait%0d", k), B + 32'h14, 32'hFFFF_FFFF);
    end
    cyc(); rd("ch1 TL reload", B + 32'h14, 32'h5);
    rd("ch1 TCON oneshot", B + 32'h18, 32'hC);
    rd("gstat ch1", B + 32'h100, 32'h2);
    chk("ch1 irq masked", 32'(irq), 32'h0);
    cyc(); cyc(); rd("ch1 TL hold", B + 32'h14, 32'h5);

    // read and write in the same cycle returns the pre-write value
    @(negedge clk);
    wdata = 32'h99;
    wr_en = 1'b1;
    rd("rw pre-write", B + 32'h30, 32'h0000_ABCD);
    @(posedge clk);
    #1 wr_en = 1'b0;
    cyc(); rd("rw post-write", B + 32'h30, 32'h99);
    cyc();
    addr  = B + 32'h30;
    rd_en = 1'b0;
    #1 chk("no read strobe", rdata, 32'h0);

    // reset mid-count on ch2
    wr(B + 32'h24, 32'h1234);
    wr(B + 32'h2C, 32'h0);
    wr(B + 32'h28, 32'h1);
    cyc(); rd("ch2 TL t0", B + 32'h24, 32'h1234);
    cyc(); rd("ch2 TL t1", B + 32'h24, 32'h1235);
    @(negedge clk);
    reset = 1'b1;
    rd("read during reset", B + 32'h24, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    reset_table("midreset");
    cyc(); cyc(); cyc();
    rd("ch2 TL idle after reset", B + 32'h24, 32'h0);
    wr(B + 32'h28, 32'h1);
    cyc(); rd("ch2 TL re-enable", B + 32'h24, 32'h0);
    cyc(); rd("ch2 TL counting", B + 32'h24, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_timer_bank.md
Name: mmio_timer_bank

Overview:
- Parametrised memory-mapped timer peripheral on the single-cycle CPU's data bus (MemBus_Address / MemBus_Write_Data / MemRead / MemWrite / Device_Read_Data).
- Sits beside the data memory inside the device layer.
- Replaces the single fixed timer with NUM_CH independent channels. Each channel has a prescaler, periodic or one-shot mode, and a sticky interrupt status with write-1-to-clear.
- Reads are combinational so the single-cycle CPU samples data in the same cycle.

Parameters:
- NUM_CH, 4, number of timer channels (1..8).
- CNT_W, 32, counter/reload/prescaler width in bits (8..32).
- BASE_ADDR, 32'h4000_0000, byte base address of the register window.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- MemBus_Address  input  32  byte address from the CPU.
- MemBus_Write_Data  input  32  store data.
- MemRead  input  1  load strobe.
- MemWrite  input  1  store strobe; sampled at the clk edge.
- Device_Read_Data  output  32  combinational read data.
- irq  output  NUM_CH  per-channel interrupt, equal to status & irq_en.

Behaviour:
- Register map, channel ch at BASE_ADDR + ch*16:
  - +0x0 TH: reload value.
  - +0x4 TL: counter.
  - +0x8 TCON: bit0 en, bit1 irq_en, bit2 status, bit3 oneshot; other bits read 0.
  - +0xC PRESC: tick divider.
- BASE_ADDR + 0x100 GSTAT: read-only; bits[NUM_CH-1:0] = status of each channel.
- Address decode:
  - Word-aligned; MemBus_Address[1:0] ignored.
  - Hit when address is in [BASE_ADDR, BASE_ADDR+0x100] and maps to an implemented register.
  - Unimplemented offsets and channels >= NUM_CH: read 0, writes ignored.
- Read path:
  - Device_Read_Data = selected register, zero-extended from CNT_W, when MemRead=1 and hit; otherwise 0.
  - Combinational, zero latency.
- Write path:
  - On the edge where MemWrite=1 and hit, the register takes MemBus_Write_Data[CNT_W-1:0]; upper bits are discarded.
  - The new value is visible to reads in the next cycle.
- TCON writes:
  - en, irq_en and oneshot load directly.
  - bit2 is write-1-to-clear; writing 0 leaves status unchanged.
- Prescaler:
  - Per-channel pcnt (CNT_W) counts only while en=1.
  - tick = en && (pcnt == PRESC); on tick pcnt <= 0, else pcnt <= pcnt+1.
  - PRESC=0 gives a tick every cycle.
  - Clearing en holds pcnt at 0.
  - Any PRESC write resets pcnt to 0.
- Counter, on tick:
  - If TL != all-ones: TL <= TL+1.
  - If TL == all-ones (overflow): TL <= TH and status <= 1. If oneshot=1, en <= 0 in the same edge.
- Channels are fully independent; no shared state except GSTAT and the read mux.
- Simultaneous events, same edge:
  - CPU write to TL and tick: write wins, no increment.
  - CPU write-1-to-clear of status and overflow: set wins (status stays 1).
  - CPU write to TCON with en=0 and overflow: TL reloads and status sets; en follows the CPU write.
  - CPU write to TH and overflow: reload uses the old TH.
- Reset (synchronous, any cycle including mid-count):
  - TH, TL, TCON, PRESC and pcnt all become 0; irq = 0.
  - Device_Read_Data is 0 while reset=1.
- No wait states and no handshake beyond the strobes. MemRead and MemWrite both high in one cycle: both act, and the read returns the pre-write value.

Decomposition:
- Shared package mmio_pkg holds:
  - Offset constants OFF_TH=0x0, OFF_TL=0x4, OFF_TCON=0x8, OFF_PRESC=0xC, OFF_GSTAT=0x100, CH_STRIDE=16.
  - TCON bit indices EN=0, IRQEN=1, STAT=2, ONESHOT=3.
- One sub-module, timer_channel, parametrised by CNT_W:
  - Holds TH, TL, TCON, PRESC and pcnt, plus the tick/overflow logic.
  - Inputs: a one-hot write-select and the write data. Outputs: register values.
  - Top level does the address decode, read mux, GSTAT and irq vector, with generate over NUM_CH.

Test Plan:
- Reset, then read all 4 channels' TH/TL/TCON/PRESC and GSTAT -> all 0, irq=4'b0000.
- ch0: TH=0xFFFF_FFF0, TL=0xFFFF_FFFE, PRESC=0, TCON=0x3 -> after 2 cycles TL=0xFFFF_FFF0, status=1, irq[0]=1, GSTAT=0x1; TL continues 0xFFFF_FFF1.
- ch1: PRESC=3, TL=0xFFFF_FFFF, TH=5, TCON=0x9 (en, oneshot, irq off) -> overflow on the 4th cycle; TL=5, status=1, en=0, irq[1]=0; TL holds 5 thereafter.
- Write TCON=0x7 to ch0 on the exact overflow edge -> status remains 1. A later write of 0x7 with no overflow -> status=0, irq[0]=0.
- Write TL=0x100 on a tick edge -> next read TL=0x100, no increment that edge. Read of 0x4000_0050 (ch5, absent) -> 0. Write there -> no register changes.
- Assert reset mid-count (ch2 TL=0x1234 running) -> next edge all registers 0. After deassert, TL stays 0 until en is rewritten.
